// File: rtl/i2c_cfg_master.sv
// I2C register-write sequencer: walks a {reg,val} table and writes each entry as
// START, dev-addr+W, reg, val, STOP with ACK checking, retry and clock stretching.
module i2c_cfg_master #(
  parameter int         CLK_HZ    = 50000000,
  parameter int         I2C_HZ    = 100000,
  parameter logic [6:0] DEV_ADDR  = 7'h39,
  parameter int         NUM_REGS  = 64,
  parameter int         MAX_RETRY = 3,
  localparam int        AW        = $clog2(NUM_REGS)
) (
  input  logic          clk50,
  input  logic          reset_n,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          scl_oe,
  output logic          sda_oe,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] fail_idx
);
  localparam int QDIV = CLK_HZ / (4 * I2C_HZ);
  localparam int CW   = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int RW   = $clog2(MAX_RETRY + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_START, S_BYTE, S_ACK, S_STOP, S_BUF,
    S_NEXT, S_RETRY, S_DONE, S_ERR
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    ph;
  logic          stretch;
  logic          load_wait;
  logic          nack;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_sel;
  logic [RW-1:0] retry;
  logic [7:0]    reg_byte;
  logic [7:0]    val_byte;
  logic [7:0]    cur_byte;
  logic          cur_bit;
  logic          tick;

  assign tick = (cnt == CW'(QDIV - 1));

  always_comb begin
    cur_byte = {DEV_ADDR, 1'b0};
    if (byte_sel == 2'd1) cur_byte = reg_byte;
    else if (byte_sel == 2'd2) cur_byte = val_byte;
  end
  assign cur_bit = cur_byte[bit_idx];

  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ph        <= 2'd0;
      stretch   <= 1'b0;
      load_wait <= 1'b0;
      nack      <= 1'b0;
      bit_idx   <= 3'd7;
      byte_sel  <= 2'd0;
      retry     <= '0;
      reg_byte  <= 8'h00;
      val_byte  <= 8'h00;
      rom_addr  <= '0;
      fail_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          error     <= 1'b0;
          rom_addr  <= '0;
          retry     <= '0;
          busy      <= 1'b1;
          load_wait <= 1'b1;
          state     <= S_LOAD;
        end
        S_LOAD: if (load_wait) begin
          load_wait <= 1'b0;
        end else begin
          reg_byte <= rom_data[15:8];
          val_byte <= rom_data[7:0];
          if (rom_data == 16'hFFFF) state <= S_DONE;
          else begin
            state <= S_START;
            cnt   <= '0;
            ph    <= 2'd0;
          end
        end
        S_NEXT: begin
          retry <= '0;
          if (rom_addr == AW'(NUM_REGS - 1)) state <= S_DONE;
          else begin
            rom_addr  <= rom_addr + 1'b1;
            load_wait <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_RETRY: begin
          retry <= retry + 1'b1;
          if (retry == RW'(MAX_RETRY)) state <= S_ERR;
          else begin
            state <= S_START;
            cnt   <= '0;
            ph    <= 2'd0;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERR: begin
          error    <= 1'b1;
          fail_idx <= rom_addr;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        S_START, S_BYTE, S_ACK, S_STOP, S_BUF: begin
          // A held-low SCL freezes P1; P2 gets a full quarter once SCL is seen high.
          if (stretch) begin
            if (scl_in) begin
              stretch <= 1'b0;
              cnt     <= '0;
              ph      <= 2'd2;
            end
          end else if (!tick) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (ph == 2'd1 && !scl_in) begin
              stretch <= 1'b1;
            end else begin
              ph <= ph + 2'd1;
              if (state == S_ACK && ph == 2'd2) nack <= sda_in;
              if (ph == 2'd3) begin
                case (state)
                  S_START: begin
                    state    <= S_BYTE;
                    byte_sel <= 2'd0;
                    bit_idx  <= 3'd7;
                  end
                  S_BYTE: begin
                    if (bit_idx == 3'd0) state <= S_ACK;
                    else bit_idx <= bit_idx - 3'd1;
                  end
                  S_ACK: begin
                    if (nack || byte_sel == 2'd2) state <= S_STOP;
                    else begin
                      byte_sel <= byte_sel + 2'd1;
                      bit_idx  <= 3'd7;
                      state    <= S_BYTE;
                    end
                  end
                  S_STOP:  state <= S_BUF;
                  S_BUF:   state <= nack ? S_RETRY : S_NEXT;
                  default: state <= S_IDLE;
                endcase
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // Pad drive follows the current phase, one clock behind it.
      case (state)
        S_START: begin scl_oe <= (ph == 2'd3);              sda_oe <= ph[1];         end
        S_BYTE:  begin scl_oe <= (ph == 2'd0 || ph == 2'd3); sda_oe <= ~cur_bit;      end
        S_ACK:   begin scl_oe <= (ph == 2'd0 || ph == 2'd3); sda_oe <= 1'b0;          end
        S_STOP:  begin scl_oe <= (ph == 2'd0);              sda_oe <= (ph < 2'd2);   end
        default: begin scl_oe <= 1'b0;                      sda_oe <= 1'b0;          end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_cfg_master.sv
// Directed bench for i2c_cfg_master: open-drain bus with a behavioural slave that
// logs bytes, ACKs/NACKs on demand and can stretch SCL.
module tb_i2c_cfg_master;
  localparam int QDIV = 4;

  logic clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  logic        reset_n, start_a, start_b;
  logic [5:0]  rom_addr_a, fail_idx_a;
  logic [1:0]  rom_addr_b, fail_idx_b;
  logic [15:0] rom_data_a, rom_data_b;
  logic [15:0] rom_a [0:63];
  logic [15:0] rom_b [0:3];
  logic        scl_oe_a, sda_oe_a, busy_a, done_a, error_a;
  logic        scl_oe_b, sda_oe_b, busy_b, done_b, error_b;
  logic        scl_hold = 1'b0, slv_sda = 1'b0;
  logic        scl, sda;

  assign scl = !(scl_oe_a | scl_oe_b | scl_hold);
  assign sda = !(sda_oe_a | sda_oe_b | slv_sda);

  always @(posedge clk50) begin
    rom_data_a <= rom_a[rom_addr_a];
    rom_data_b <= rom_b[rom_addr_b];
  end

  i2c_cfg_master #(.CLK_HZ(1600000), .I2C_HZ(100000), .DEV_ADDR(7'h39),
                   .NUM_REGS(64), .MAX_RETRY(3)) dut_a (
    .clk50(clk50), .reset_n(reset_n), .start(start_a), .rom_addr(rom_addr_a),
    .rom_data(rom_data_a), .scl_in(scl), .sda_in(sda), .scl_oe(scl_oe_a),
    .sda_oe(sda_oe_a), .busy(busy_a), .done(done_a), .error(error_a),
    .fail_idx(fail_idx_a));

  i2c_cfg_master #(.CLK_HZ(1600000), .I2C_HZ(100000), .DEV_ADDR(7'h39),
                   .NUM_REGS(4), .MAX_RETRY(3)) dut_b (
    .clk50(clk50), .reset_n(reset_n), .start(start_b), .rom_addr(rom_addr_b),
    .rom_data(rom_data_b), .scl_in(scl), .sda_in(sda), .scl_oe(scl_oe_b),
    .sda_oe(sda_oe_b), .busy(busy_b), .done(done_b), .error(error_b),
    .fail_idx(fail_idx_b));

  // Slave model state (written only by the slave process)
  logic [7:0] byte_q [$];
  logic [7:0] shreg = 8'h00;
  logic       scl_p = 1'b1, sda_p = 1'b1, str_used = 1'b0, str_flag = 1'b0;
  int cyc = 0, bitcnt = 0, byte_no = 0, stops = 0, hold_cnt = 0, nack_cnt = 0;
  int last_rise = 0, scl_period = 0, str_high = 0, done_cnt_a = 0, done_cnt_b = 0;
  // Slave controls (written only by the stimulus)
  int nack_budget = 0, nack_base = 0, nack_byte = 0;
  logic [7:0] nack_val = 8'h00;
  logic       str_en = 1'b0;

  always @(negedge clk50) begin
    logic s_c, s_d;
    s_c = scl;
    s_d = sda;
    cyc++;
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
    if (!reset_n) begin
      slv_sda  = 1'b0;
      scl_hold = 1'b0;
      hold_cnt = 0;
    end else begin
      if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) begin scl_hold = 1'b0; str_flag = 1'b1; end
      end
      if (s_c && scl_p && sda_p && !s_d) begin
        bitcnt = 0; byte_no = 0;
      end else if (s_c && scl_p && !sda_p && s_d) begin
        stops++;
        $display("txn %0d ended with STOP, bytes logged so far %0d", stops, byte_q.size());
      end else if (s_c && !scl_p) begin
        if (bitcnt >= 1 && bitcnt <= 7) scl_period = cyc - last_rise;
        last_rise = cyc;
        if (bitcnt < 8) begin
          shreg = {shreg[6:0], s_d};
          bitcnt++;
          if (bitcnt == 8) byte_q.push_back(shreg);
        end else bitcnt = 9;
      end else if (!s_c && scl_p) begin
        if (str_flag) begin str_high = cyc - last_rise; str_flag = 1'b0; end
        if (bitcnt == 8) begin
          if ((nack_cnt - nack_base) < nack_budget && byte_no == nack_byte && shreg == nack_val)
            nack_cnt++;
          else slv_sda = 1'b1;
        end else if (bitcnt == 9) begin
          slv_sda = 1'b0; bitcnt = 0; byte_no++;
        end else if (str_en && !str_used && byte_no == 2 && bitcnt == 4) begin
          scl_hold = 1'b1; hold_cnt = 37; str_used = 1'b1;
        end
      end
    end
    scl_p = s_c;
    sda_p = s_d;
  end

  int checks = 0, errors = 0;
  int base_bytes = 0, base_stops = 0, base_done_a = 0, base_done_b = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    base_bytes  = byte_q.size();
    base_stops  = stops;
    base_done_a = done_cnt_a;
    base_done_b = done_cnt_b;
  endtask

  task automatic chk_bytes(input string tag);
    chk({tag, "_nbytes"}, byte_q.size() - base_bytes, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base_bytes + i < byte_q.size())
        chk($sformatf("%s_byte%0d", tag, i), {24'h0, byte_q[base_bytes + i]}, {24'h0, exp_q[i]});
  endtask

  task automatic pulse(input logic sel);
    @(negedge clk50);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk50);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input logic sel);
    int n = 0;
    while ((sel ? busy_b : busy_a) && n < 20000) begin
      @(negedge clk50);
      n++;
    end
    repeat (4) @(negedge clk50);
    chk({tag, "_finished"}, n < 20000, 1);
  endtask

  initial begin
    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 64; i++) rom_a[i] = 16'hFFFF;
    rom_b[0] = 16'h0102; rom_b[1] = 16'h0304; rom_b[2] = 16'h0506; rom_b[3] = 16'h0708;
    repeat (3) @(negedge clk50);
    chk("rst_scl_oe", scl_oe_a, 0);
    chk("rst_sda_oe", sda_oe_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_error", error_a, 0);
    chk("rst_rom_addr", rom_addr_a, 0);
    chk("rst_fail_idx", fail_idx_a, 0);
    reset_n = 1'b1;

    // 1: two entries plus terminator, all ACKed
    rom_a[0] = 16'h4110; rom_a[1] = 16'h9803;
    mark(); pulse(1'b0);
    chk("t1_busy", busy_a, 1);
    wait_idle("t1", 1'b0);
    exp_q = '{8'h72, 8'h41, 8'h10, 8'h72, 8'h98, 8'h03};
    chk_bytes("t1");
    chk("t1_stops", stops - base_stops, 2);
    chk("t1_done", done_cnt_a - base_done_a, 1);
    chk("t1_error", error_a, 0);
    chk("t1_scl_period", scl_period, 16);

    // 2: reg byte of entry 1 NACKed twice
    nack_byte = 1; nack_val = 8'h98; nack_base = nack_cnt; nack_budget = 2;
    mark(); pulse(1'b0); wait_idle("t2", 1'b0);
    exp_q = '{8'h72, 8'h41, 8'h10, 8'h72, 8'h98, 8'h72, 8'h98, 8'h72, 8'h98, 8'h03};
    chk_bytes("t2");
    chk("t2_nacks", nack_cnt - nack_base, 2);
    chk("t2_stops", stops - base_stops, 4);
    chk("t2_done", done_cnt_a - base_done_a, 1);
    chk("t2_error", error_a, 0);

    // 3: address never ACKed
    nack_byte = 0; nack_val = 8'h72; nack_base = nack_cnt; nack_budget = 100;
    mark(); pulse(1'b0); wait_idle("t3", 1'b0);
    exp_q = '{8'h72, 8'h72, 8'h72, 8'h72};
    chk_bytes("t3");
    chk("t3_stops", stops - base_stops, 4);
    chk("t3_error", error_a, 1);
    chk("t3_fail_idx", fail_idx_a, 0);
    chk("t3_done", done_cnt_a - base_done_a, 0);
    nack_budget = 0;

    // 4: SCL stretched 37 clks during bit 3 of val
    rom_a[1] = 16'hFFFF; str_en = 1'b1;
    mark(); pulse(1'b0);
    chk("t4_error_cleared", error_a, 0);
    wait_idle("t4", 1'b0);
    exp_q = '{8'h72, 8'h41, 8'h10};
    chk_bytes("t4");
    chk("t4_stretched", str_used, 1);
    chk("t4_high_after_release", (str_high >= QDIV && str_high <= QDIV + 2), 1);
    chk("t4_done", done_cnt_a - base_done_a, 1);
    str_en = 1'b0;

    // 5: reset in the middle of the address byte
    rom_a[1] = 16'h9803;
    mark(); pulse(1'b0);
    repeat (70) @(negedge clk50);
    chk("t5_busy_before", busy_a, 1);
    reset_n = 1'b0;
    @(posedge clk50); #1;
    chk("t5_scl_oe", scl_oe_a, 0);
    chk("t5_sda_oe", sda_oe_a, 0);
    chk("t5_busy", busy_a, 0);
    @(negedge clk50);
    reset_n = 1'b1;
    repeat (4) @(negedge clk50);
    mark(); pulse(1'b0); wait_idle("t5", 1'b0);
    exp_q = '{8'h72, 8'h41, 8'h10, 8'h72, 8'h98, 8'h03};
    chk_bytes("t5");
    chk("t5_done", done_cnt_a - base_done_a, 1);

    // 6: four-entry table with no terminator, extra start while busy
    mark(); pulse(1'b1);
    repeat (300) @(negedge clk50);
    chk("t6_busy", busy_b, 1);
    pulse(1'b1);
    wait_idle("t6", 1'b1);
    exp_q = '{8'h72, 8'h01, 8'h02, 8'h72, 8'h03, 8'h04,
              8'h72, 8'h05, 8'h06, 8'h72, 8'h07, 8'h08};
    chk_bytes("t6");
    chk("t6_stops", stops - base_stops, 4);
    chk("t6_done", done_cnt_b - base_done_b, 1);
    chk("t6_error", error_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
